fpu_issue_ctrl: RTL and testbench

- Initiator that drives the FPU top-level command interface (cmd / din1 / din2 / dval, returning result / rdy).
- Accepts operation requests over a valid/ready stream and buffers them in a small FIFO.
- Issues one operation at a time, holding cmd stable until completion, and returns a tagged, status-coded response over a second valid/ready stream.
- Sits between the bus/register front-end and the FPU top-level.

---
 rtl/fpu_pkg.sv | 52 +++++
 rtl/fpu_req_fifo.sv | 49 ++++
 rtl/fpu_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, status/state enums, request bundle
// and opcode classifiers shared by the FPU issue path.
package fpu_pkg;

  localparam logic [3:0] CMD_FPU_SP_ADD = 4'b0001;
  localparam logic [3:0] CMD_FPU_SP_MUL = 4'b0010;
  localparam logic [3:0] CMD_FPU_SP_DIV = 4'b0011;
  localparam logic [3:0] CMD_FPU_DP_ADD = 4'b0101;
  localparam logic [3:0] CMD_FPU_DP_MUL = 4'b0110;
  localparam logic [3:0] CMD_FPU_DP_DIV = 4'b0111;

  // Widest tag carried in the bundle; users keep [TAG_W-1:0].
  localparam int TAG_W_MAX = 16;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ILLEGAL = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [3:0]           cmd;
    logic [63:0]          din1;
    logic [63:0]          din2;
    logic [TAG_W_MAX-1:0] tag;
  } fpu_req_t;

  function automatic logic is_sp_cmd(
    input logic [3:0] c
  );
    return c inside {CMD_FPU_SP_ADD,
                     CMD_FPU_SP_MUL,
                     CMD_FPU_SP_DIV};
  endfunction

  function automatic logic is_legal_cmd(
    input logic [3:0] c
  );
    return is_sp_cmd(c) ||
           (c inside {CMD_FPU_DP_ADD,
                      CMD_FPU_DP_MUL,
                      CMD_FPU_DP_DIV});
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// fpu_req_fifo: synchronous request FIFO, DEPTH entries.
// Ports: clk, rst, push/din, pop/dout, full, empty.
module fpu_req_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  fpu_req_t din,
  input  logic     pop,
  output fpu_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  fpu_req_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Same slot, different lap: the MSB tells full from empty.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues FPU requests, issues one at a time
// on cmd/din/dval, returns tagged status-coded responses.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [63:0]      req_din1,
  input  logic [63:0]      req_din2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_status,
  output logic [3:0]       fpu_cmd,
  output logic [63:0]      fpu_din1,
  output logic [63:0]      fpu_din2,
  output logic             fpu_dval,
  input  logic [63:0]      fpu_result,
  input  logic             fpu_rdy,
  output logic             busy
);

  state_e   state;
  state_e   state_nxt;
  fpu_req_t push_req;
  fpu_req_t head;
  fpu_req_t op;
  status_e  status_q;
  logic     push;
  logic     pop;
  logic     full;
  logic     empty;
  logic     legal;
  logic     tmo_hit;
  logic [15:0] timer;
  logic     unused_tag;

  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;

  always_comb begin
    push_req             = '0;
    push_req.cmd         = req_cmd;
    push_req.din1        = req_din1;
    push_req.din2        = req_din2;
    push_req.tag[TAG_W-1:0] = req_tag;
  end

  fpu_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_req),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign legal   = is_legal_cmd(head.cmd);
  assign tmo_hit = (timer == 16'(TIMEOUT - 1));
  assign unused_tag = ^{head.tag, op.tag};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (!empty) state_nxt = legal ? ISSUE : RESP;
      ISSUE:
        state_nxt = WAIT;
      WAIT:
        if (fpu_rdy || tmo_hit) state_nxt = RESP;
      RESP:
        if (rsp_ready) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // FPU command lines are zero outside ISSUE/WAIT so the
  // FPU output mux is deselected between operations.
  always_comb begin
    pop       = 1'b0;
    fpu_dval  = 1'b0;
    fpu_cmd   = '0;
    fpu_din1  = '0;
    fpu_din2  = '0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: pop = !empty;
      ISSUE: begin
        fpu_dval = 1'b1;
        fpu_cmd  = op.cmd;
        fpu_din1 = op.din1;
        fpu_din2 = op.din2;
      end
      WAIT: begin
        fpu_cmd  = op.cmd;
        fpu_din1 = op.din1;
        fpu_din2 = op.din2;
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op         <= '0;
      timer      <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      status_q   <= ST_OK;
    end else begin
      if (pop) op <= head;
      if (pop && !legal) begin
        rsp_result <= '0;
        rsp_tag    <= head.tag[TAG_W-1:0];
        status_q   <= ST_ILLEGAL;
      end
      if (state == ISSUE) timer <= '0;
      if (state == WAIT) begin
        // rdy wins over a coincident timeout
        if (fpu_rdy) begin
          rsp_result <= is_sp_cmd(op.cmd) ?
                        {32'h0, fpu_result[31:0]} :
                        fpu_result;
          rsp_tag    <= op.tag[TAG_W-1:0];
          status_q   <= ST_OK;
        end else if (tmo_hit) begin
          rsp_result <= '0;
          rsp_tag    <= op.tag[TAG_W-1:0];
          status_q   <= ST_TIMEOUT;
        end else if (timer != 16'hFFFF) begin
          timer <= timer + 16'd1;
        end
      end
    end
  end

  assign rsp_status = status_q;
  assign busy       = !empty || (state != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench for fpu_issue_ctrl
// with a latency-programmable FPU responder model.
module tb_fpu_issue_ctrl;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_cmd;
  logic [63:0]   req_din1;
  logic [63:0]   req_din2;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [63:0]   rsp_result;
  logic [TW-1:0] rsp_tag;
  logic [1:0]    rsp_status;
  logic [3:0]    fpu_cmd;
  logic [63:0]   fpu_din1;
  logic [63:0]   fpu_din2;
  logic          fpu_dval;
  logic [63:0]   fpu_result;
  logic          fpu_rdy;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .FIFO_DEPTH(4),
    .TIMEOUT   (16),
    .TAG_W     (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_din1  (req_din1),
    .req_din2  (req_din2),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_tag   (rsp_tag),
    .rsp_status(rsp_status),
    .fpu_cmd   (fpu_cmd),
    .fpu_din1  (fpu_din1),
    .fpu_din2  (fpu_din2),
    .fpu_dval  (fpu_dval),
    .fpu_result(fpu_result),
    .fpu_rdy   (fpu_rdy),
    .busy      (busy)
  );

  // FPU model: rdy high in cycle dval+lat unless never set.
  logic        pending = 1'b0;
  int          wcnt = 0;
  int          lat = 4;
  bit          never = 1'b0;
  bit          echo = 1'b0;
  logic [63:0] model_res = '0;
  logic [63:0] cap_din1 = '0;

  always @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      wcnt    <= 0;
    end else if (fpu_dval) begin
      pending  <= 1'b1;
      wcnt     <= 1;
      cap_din1 <= fpu_din1;
    end else if (fpu_rdy) begin
      pending <= 1'b0;
    end else if (pending) begin
      wcnt <= wcnt + 1;
    end
  end

  assign fpu_rdy = pending && !never && (wcnt == lat);
  assign fpu_result = echo ? cap_din1 : model_res;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic run_one(
    input  logic [3:0]  c,
    input  logic [63:0] d1,
    input  logic [63:0] d2,
    input  logic [3:0]  t,
    output bit          got,
    output int          dv,
    output int          dcyc,
    output int          rcyc,
    output logic [63:0] r,
    output logic [3:0]  rt,
    output logic [1:0]  rs,
    output bit          hold_ok,
    output bit          zero_ok
  );
    got = 0; dv = 0; dcyc = -1; rcyc = -1;
    r = 'x; rt = 'x; rs = 'x;
    hold_ok = 1; zero_ok = 1;
    req_valid = 1; req_cmd = c;
    req_din1 = d1; req_din2 = d2; req_tag = t;
    @(negedge clk);
    req_valid = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (fpu_dval) begin
        dv++;
        dcyc = cyc;
      end
      if (dv > 0 && !rsp_valid &&
          (fpu_cmd !== c || fpu_din1 !== d1 ||
           fpu_din2 !== d2))
        hold_ok = 0;
      if (rsp_valid) begin
        got = 1; rcyc = cyc;
        r = rsp_result; rt = rsp_tag; rs = rsp_status;
        if (fpu_cmd !== 0 || fpu_din1 !== 0 ||
            fpu_din2 !== 0)
          zero_ok = 0;
        break;
      end
      if (dv == 0 && fpu_cmd !== 0) zero_ok = 0;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 0; rsp_ready = 0;
    req_cmd = 0; req_din1 = 0; req_din2 = 0; req_tag = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0)
      $display("FAIL rst_req_ready got=%b exp=0", req_ready);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0 || fpu_dval !== 1'b0 ||
        busy !== 1'b0)
      $display("FAIL rst_ctl got v=%b d=%b b=%b exp=000",
               rsp_valid, fpu_dval, busy);
    else n_pass++;
    n_checks++;
    if (rsp_result !== 64'h0 || rsp_tag !== 4'h0 ||
        rsp_status !== 2'b00)
      $display("FAIL rst_rsp got r=%h t=%h s=%b exp=0",
               rsp_result, rsp_tag, rsp_status);
    else n_pass++;
    n_checks++;
    if (fpu_cmd !== 4'h0 || fpu_din1 !== 64'h0 ||
        fpu_din2 !== 64'h0)
      $display("FAIL rst_fpu got c=%h d1=%h d2=%h exp=0",
               fpu_cmd, fpu_din1, fpu_din2);
    else n_pass++;
    rst = 0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1)
      $display("FAIL post_rst_ready got=%b exp=1", req_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_sp_add();
    bit got, hok, zok;
    int dv, dc, rc;
    logic [63:0] r;
    logic [3:0] rt;
    logic [1:0] rs;
    lat = 4; never = 0; echo = 0;
    model_res = 64'hFFFF_FFFF_4040_0000;
    rsp_ready = 1;
    run_one(4'b0001, 64'h3F80_0000, 64'h4000_0000, 4'd3,
            got, dv, dc, rc, r, rt, rs, hok, zok);
    n_checks++;
    if (dv != 1 || dc != 2)
      $display("FAIL sp_dval got n=%0d cyc=%0d exp n=1 cyc=2",
               dv, dc);
    else n_pass++;
    n_checks++;
    if (!got || rc != 7)
      $display("FAIL sp_rsp_cyc got=%0d exp=7", rc);
    else n_pass++;
    n_checks++;
    if (r !== 64'h0000_0000_4040_0000)
      $display("FAIL sp_result got=%h exp=%h",
               r, 64'h0000_0000_4040_0000);
    else n_pass++;
    n_checks++;
    if (rt !== 4'd3 || rs !== 2'b00)
      $display("FAIL sp_tag_st got t=%0d s=%b exp t=3 s=00",
               rt, rs);
    else n_pass++;
    n_checks++;
    if (!hok || !zok)
      $display("FAIL sp_cmd_hold got hold=%b zero=%b exp=11",
               hok, zok);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL sp_idle got v=%b b=%b exp=00",
               rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_dp_mul();
    bit got, hok, zok;
    int dv, dc, rc;
    logic [63:0] r;
    logic [3:0] rt;
    logic [1:0] rs;
    lat = 3; never = 0; echo = 0;
    model_res = 64'h4018_0000_0000_0000;
    run_one(4'b0110, 64'h4000_0000_0000_0000,
            64'h4008_0000_0000_0000, 4'd5,
            got, dv, dc, rc, r, rt, rs, hok, zok);
    n_checks++;
    if (r !== 64'h4018_0000_0000_0000)
      $display("FAIL dp_result got=%h exp=%h",
               r, 64'h4018_0000_0000_0000);
    else n_pass++;
    n_checks++;
    if (rs !== 2'b00 || rt !== 4'd5)
      $display("FAIL dp_tag_st got t=%0d s=%b exp t=5 s=00",
               rt, rs);
    else n_pass++;
    n_checks++;
    if (!hok)
      $display("FAIL dp_din_stable got=0 exp=1");
    else n_pass++;
    n_checks++;
    if (dv != 1 || rc != dc + 4)
      $display("FAIL dp_timing got n=%0d d=%0d r=%0d exp r=d+4",
               dv, dc, rc);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bit got, hok, zok;
    int dv, dc, rc;
    logic [63:0] r;
    logic [3:0] rt;
    logic [1:0] rs;
    model_res = 64'h1234_5678_9ABC_DEF0;
    run_one(4'b0100, 64'h1, 64'h2, 4'd7,
            got, dv, dc, rc, r, rt, rs, hok, zok);
    n_checks++;
    if (dv != 0)
      $display("FAIL ill_no_dval got=%0d exp=0", dv);
    else n_pass++;
    n_checks++;
    if (!got || rc != 2)
      $display("FAIL ill_rsp_cyc got=%0d exp=2", rc);
    else n_pass++;
    n_checks++;
    if (rs !== 2'b01 || r !== 64'h0 || rt !== 4'd7)
      $display("FAIL ill_rsp got s=%b r=%h t=%0d exp 01/0/7",
               rs, r, rt);
    else n_pass++;
    n_checks++;
    if (!zok)
      $display("FAIL ill_fpu_idle got=0 exp=1");
    else n_pass++;
  endtask

  task automatic test_timeout();
    int dv = 0, da = -1, db = -1, ra = -1, rb = -1, nr = 0;
    logic [63:0] res_a = 'x, res_b = 'x;
    logic [3:0]  tag_a = 'x, tag_b = 'x;
    logic [1:0]  st_a = 'x, st_b = 'x;
    never = 1; echo = 0; lat = 2;
    model_res = 64'h4010_0000_0000_0000;
    rsp_ready = 1;
    req_valid = 1; req_cmd = 4'b0010;
    req_din1 = 64'h1; req_din2 = 64'h2; req_tag = 4'd9;
    @(negedge clk);
    req_cmd = 4'b0101; req_din1 = 64'h3;
    req_din2 = 64'h4; req_tag = 4'd10;
    @(negedge clk);
    req_valid = 0;
    for (int cyc = 2; cyc <= 80; cyc++) begin
      if (fpu_dval) begin
        dv++;
        if (dv == 1) da = cyc;
        else db = cyc;
      end
      if (rsp_valid) begin
        nr++;
        if (nr == 1) begin
          ra = cyc; res_a = rsp_result;
          tag_a = rsp_tag; st_a = rsp_status;
          never = 0;
        end else begin
          rb = cyc; res_b = rsp_result;
          tag_b = rsp_tag; st_b = rsp_status;
          break;
        end
      end
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (da != 2 || ra != da + 17)
      $display("FAIL tmo_latency got d=%0d r=%0d exp d=2 r=19",
               da, ra);
    else n_pass++;
    n_checks++;
    if (st_a !== 2'b10 || res_a !== 64'h0 || tag_a !== 4'd9)
      $display("FAIL tmo_rsp got s=%b r=%h t=%0d exp 10/0/9",
               st_a, res_a, tag_a);
    else n_pass++;
    n_checks++;
    if (dv != 2 || rb != db + 3)
      $display("FAIL tmo_next got n=%0d d=%0d r=%0d exp r=d+3",
               dv, db, rb);
    else n_pass++;
    n_checks++;
    if (st_b !== 2'b00 || tag_b !== 4'd10 ||
        res_b !== 64'h4010_0000_0000_0000)
      $display("FAIL tmo_next_rsp got s=%b t=%0d r=%h",
               st_b, tag_b, res_b);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc = 0, nr = 0, acc_cyc = -1;
    bit pushed5 = 0;
    logic [3:0]  tags [6];
    logic [63:0] res  [6];
    logic [1:0]  sts  [6];
    rsp_ready = 0; echo = 1; lat = 2; never = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; req_cmd = 4'b0001;
      req_din1 = {32'hDEAD_BEEF, 32'(256 + acc)};
      req_din2 = 64'h0; req_tag = acc[3:0];
      #1;
      if (req_ready) acc++;
      @(negedge clk);
    end
    n_checks++;
    if (acc != 5 || req_ready !== 1'b0)
      $display("FAIL bp_accept got n=%0d rdy=%b exp n=5 rdy=0",
               acc, req_ready);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 ||
        busy !== 1'b1)
      $display("FAIL bp_hold got v=%b t=%0d b=%b exp 1/0/1",
               rsp_valid, rsp_tag, busy);
    else n_pass++;
    rsp_ready = 1;
    for (int cyc = 0; cyc <= 150; cyc++) begin
      if (pushed5) req_valid = 0;
      else begin
        #1;
        if (req_ready) begin
          pushed5 = 1;
          acc_cyc = cyc;
        end
      end
      if (rsp_valid) begin
        if (nr < 6) begin
          tags[nr] = rsp_tag;
          res[nr]  = rsp_result;
          sts[nr]  = rsp_status;
        end
        nr++;
      end
      if (nr >= 6) break;
      @(negedge clk);
    end
    req_valid = 0;
    @(negedge clk);
    n_checks++;
    if (acc_cyc != 2 || nr != 6)
      $display("FAIL bp_refill got acc=%0d n=%0d exp 2/6",
               acc_cyc, nr);
    else n_pass++;
    for (int k = 0; k < 6 && k < nr; k++) begin
      n_checks++;
      if (tags[k] !== 4'(k) || sts[k] !== 2'b00)
        $display("FAIL bp_order[%0d] got t=%0d s=%b exp t=%0d",
                 k, tags[k], sts[k], k);
      else n_pass++;
      n_checks++;
      if (res[k] !== {32'h0, 32'(256 + k)})
        $display("FAIL bp_result[%0d] got=%h exp=%h",
                 k, res[k], {32'h0, 32'(256 + k)});
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL bp_drain got busy=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int nv = 0, nd = 0;
    never = 1; echo = 0; rsp_ready = 1;
    for (int t = 1; t <= 3; t++) begin
      req_valid = 1; req_cmd = 4'b0101;
      req_din1 = 64'(t); req_din2 = 64'h0;
      req_tag = 4'(t);
      @(negedge clk);
    end
    req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || fpu_cmd !== 4'b0101)
      $display("FAIL rmw_in_wait got b=%b c=%h exp 1/5",
               busy, fpu_cmd);
    else n_pass++;
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 ||
        fpu_cmd !== 4'h0)
      $display("FAIL rmw_cleared got b=%b v=%b c=%h exp 0/0/0",
               busy, rsp_valid, fpu_cmd);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1)
      $display("FAIL rmw_ready got=%b exp=1", req_ready);
    else n_pass++;
    never = 0; lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
      if (fpu_dval) nd++;
    end
    n_checks++;
    if (nv != 0 || nd != 0)
      $display("FAIL rmw_stale got rsp=%0d dval=%0d exp 0/0",
               nv, nd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sp_add();
    test_dp_mul();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
